// File: rtl/hyperbus_resp_pkg.sv
// hyperbus_resp_pkg: shared types and constants for the HyperBus responder.
package hyperbus_resp_pkg;
  typedef enum logic [2:0] {IDLE, CA, LAT, REGWR, READ, WRITE, WAITCS} state_t;
  typedef struct packed {
    logic        rd;
    logic        regsp;
    logic        lin;
    logic [28:0] row;
    logic [12:0] rsvd;
    logic [2:0]  col;
  } ca_t;
  localparam int MIN_LAT = 3;
  localparam int CR0_LAT_LSB = 4;
  localparam int CR0_LAT_W = 4;
  function automatic logic [4:0] calc_lat(input logic [3:0] f, input logic dbl);
    logic [4:0] l;
    l = (f < 4'(MIN_LAT)) ? 5'(MIN_LAT) : {1'b0, f};
    return dbl ? l << 1 : l;
  endfunction
endpackage

// File: rtl/hyperbus_resp_addr_gen.sv
// hyperbus_resp_addr_gen: burst word-address generator, linear or wrapped within WRAP_WORDS.
module hyperbus_resp_addr_gen #(
  parameter int ADDR_W = 20,
  parameter int WRAP_WORDS = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_linear,
  input  logic              i_step,
  output logic [ADDR_W-1:0] o_addr
);
  localparam int WB = $clog2(WRAP_WORDS);
  logic [ADDR_W-1:0] r_addr;
  logic              r_lin;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_addr <= '0;
      r_lin  <= 1'b0;
    end else if (i_load) begin
      r_addr <= i_addr;
      r_lin  <= i_linear;
    end else if (i_step) begin
      r_addr <= r_lin ? r_addr + ADDR_W'(1) : {r_addr[ADDR_W-1:WB], r_addr[WB-1:0] + WB'(1)};
    end
  assign o_addr = r_addr;
endmodule

// File: rtl/hyperbus_responder.sv
// hyperbus_responder: HyperRAM-side responder serving HyperBus bursts from an SRAM port.
// Define HYPERBUS_RESP_DOUBLE_LAT_EN to force doubled latency on every memory-space access.
module hyperbus_responder
  import hyperbus_resp_pkg::*;
#(
  parameter int          ADDR_W      = 20,
  parameter int          DEFAULT_LAT = 6,
  parameter int          WRAP_WORDS  = 16,
  parameter logic [15:0] ID0_VALUE   = 16'h0C81
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hyper_reset_ni,
  input  logic              hyper_cs_ni,
  input  logic [15:0]       hyper_dq_i,
  output logic [15:0]       hyper_dq_o,
  output logic              hyper_dq_oe_o,
  input  logic [1:0]        hyper_rwds_i,
  output logic [1:0]        hyper_rwds_o,
  output logic              hyper_rwds_oe_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_wdata_o,
  output logic [1:0]        mem_be_o,
  input  logic [15:0]       mem_rdata_i,
  output logic [15:0]       cr0_o
);
  localparam logic [15:0] CR0_RST = {8'h8F, 4'(DEFAULT_LAT), 4'hF};
  state_t      r_state;
  ca_t         r_ca;
  logic [4:0]  r_cnt;
  logic [15:0] r_cr0;
  logic [31:0] w_wa_nxt;
  logic [4:0]  w_lat;
  logic        w_dbl, w_load, w_act, w_mem, w_unused;
`ifdef HYPERBUS_RESP_DOUBLE_LAT_EN
  assign w_dbl = ~r_ca.regsp;
`else
  assign w_dbl = 1'b0;
`endif
  // CA[15:0] arrives in the last CA cycle, so the start address is built from the live bus word
  assign w_wa_nxt = {r_ca.row, hyper_dq_i[2:0]};
  assign w_lat    = calc_lat(r_cr0[CR0_LAT_LSB +: CR0_LAT_W], w_dbl);
  assign w_act    = ~hyper_cs_ni;
  assign w_mem    = ~r_ca.regsp;
  assign w_load   = w_act && hyper_reset_ni && r_state == CA && r_cnt == 5'd1;
  assign w_unused = ^{r_ca.rsvd, w_wa_nxt[31:ADDR_W]};
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_state <= IDLE;
      r_ca    <= '0;
      r_cnt   <= '0;
      r_cr0   <= CR0_RST;
    end else if (!hyper_reset_ni) begin
      r_state <= IDLE;
      r_cr0   <= CR0_RST;
    end else if (hyper_cs_ni) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          r_ca[47:32] <= hyper_dq_i;
          r_cnt       <= '0;
          r_state     <= CA;
        end
        CA: if (r_cnt == '0) begin
          r_ca[31:16] <= hyper_dq_i;
          r_cnt       <= 5'd1;
        end else begin
          r_ca[15:0] <= hyper_dq_i;
          r_cnt      <= w_lat - 5'd2;
          r_state    <= (r_ca.regsp && !r_ca.rd) ? REGWR : LAT;
        end
        LAT: if (r_cnt == '0) r_state <= r_ca.rd ? READ : WRITE;
        else r_cnt <= r_cnt - 5'd1;
        REGWR: begin
          if (r_ca.row[8]) r_cr0 <= hyper_dq_i;
          r_state <= WAITCS;
        end
        default: r_state <= r_state;
      endcase
    end
  // read request leads the data beat by one cycle because SRAM read data lags its strobe
  assign mem_req_o   = w_act && w_mem && (r_state == READ || r_state == WRITE ||
                       (r_state == LAT && r_cnt == '0 && r_ca.rd));
  assign mem_we_o    = mem_req_o && r_state == WRITE;
  assign mem_wdata_o = mem_we_o ? hyper_dq_i : '0;
  assign mem_be_o    = mem_we_o ? ~hyper_rwds_i : '0;
  assign hyper_dq_oe_o   = r_state == READ;
  assign hyper_dq_o      = r_state != READ ? '0 : r_ca.regsp ? (r_ca.row[8] ? r_cr0 : ID0_VALUE) : mem_rdata_i;
  assign hyper_rwds_oe_o = r_state == CA || r_state == READ;
  assign hyper_rwds_o    = r_state == READ ? 2'b10 : {2{r_state == CA && w_dbl}};
  assign cr0_o           = r_cr0;
  hyperbus_resp_addr_gen #(.ADDR_W(ADDR_W), .WRAP_WORDS(WRAP_WORDS)) u_addr_gen (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_load   (w_load),
    .i_addr   (w_wa_nxt[ADDR_W-1:0]),
    .i_linear (r_ca.lin),
    .i_step   (mem_req_o),
    .o_addr   (mem_addr_o)
  );
endmodule

// File: tb/tb_hyperbus_responder.sv
// tb_hyperbus_responder: directed bench for hyperbus_responder with a bench-owned SRAM model.
module tb_hyperbus_responder;
  localparam int ADDR_W = 20;
`ifdef HYPERBUS_RESP_DOUBLE_LAT_EN
  localparam int MEM_LAT = 12;
  localparam int LAT3 = 6;
  localparam logic [1:0] CA_RW = 2'b11;
`else
  localparam int MEM_LAT = 6;
  localparam int LAT3 = 3;
  localparam logic [1:0] CA_RW = 2'b00;
`endif
  logic clk_i = 1'b0, rst_i = 1'b1, hyper_reset_ni = 1'b1, hyper_cs_ni = 1'b1;
  logic [15:0] hyper_dq_i = '0, hyper_dq_o, mem_wdata_o, mem_rdata_i, cr0_o;
  logic [1:0] hyper_rwds_i = '0, hyper_rwds_o, mem_be_o;
  logic hyper_dq_oe_o, hyper_rwds_oe_o, mem_req_o, mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [15:0] mem [0:1023];
  int passed = 0, total = 0;
  logic ca_oe, req_after, oe_after, any_oe;
  logic [1:0] ca_rwds;
  logic [15:0] beats [8];
  logic [1:0] beat_rwds [8];
  logic [ADDR_W-1:0] req_addr [8];
  int nbeat, nreq, first_beat, fill_req;
  logic [15:0] wdat [4];
  logic [1:0] wrw [4];
  logic wreq [4], wwe [4];
  logic [ADDR_W-1:0] waddr [4];
  logic [1:0] wbe [4];
  logic [15:0] wwd [4];

  hyperbus_responder dut (
    .clk_i(clk_i), .rst_i(rst_i), .hyper_reset_ni(hyper_reset_ni), .hyper_cs_ni(hyper_cs_ni),
    .hyper_dq_i(hyper_dq_i), .hyper_dq_o(hyper_dq_o), .hyper_dq_oe_o(hyper_dq_oe_o),
    .hyper_rwds_i(hyper_rwds_i), .hyper_rwds_o(hyper_rwds_o), .hyper_rwds_oe_o(hyper_rwds_oe_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i), .cr0_o(cr0_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i)
    if (rst_i) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'hAAAA;
      mem_rdata_i <= '0;
    end else if (mem_req_o) begin
      if (mem_we_o) begin
        if (mem_be_o[1]) mem[mem_addr_o[9:0]][15:8] <= mem_wdata_o[15:8];
        if (mem_be_o[0]) mem[mem_addr_o[9:0]][7:0] <= mem_wdata_o[7:0];
      end else mem_rdata_i <= mem[mem_addr_o[9:0]];
    end

  task automatic drive(input logic cs_n, input logic [15:0] dq, input logic [1:0] rw);
    @(negedge clk_i);
    hyper_cs_ni = cs_n;
    hyper_dq_i = dq;
    hyper_rwds_i = rw;
    #2;
  endtask

  task automatic send_ca(input logic rd, input logic rs, input logic lin, input logic [31:0] a);
    logic [47:0] ca;
    ca = {rd, rs, lin, a[31:3], 13'd0, a[2:0]};
    drive(1'b0, ca[47:32], 2'b00);
    drive(1'b0, ca[31:16], 2'b00);
    drive(1'b0, ca[15:0], 2'b00);
    ca_oe = hyper_rwds_oe_o;
    ca_rwds = hyper_rwds_o;
  endtask

  task automatic end_txn();
    drive(1'b1, 16'h0, 2'b00);
    req_after = mem_req_o;
    drive(1'b1, 16'h0, 2'b00);
    oe_after = hyper_dq_oe_o | hyper_rwds_oe_o;
  endtask

  task automatic read_txn(input logic rs, input logic lin, input logic [31:0] a, input int n);
    nbeat = 0;
    nreq = 0;
    first_beat = -1;
    send_ca(1'b1, rs, lin, a);
    for (int k = 1; k <= 40 && nbeat < n; k++) begin
      drive(1'b0, 16'h0, 2'b00);
      if (mem_req_o && nreq < 8) begin
        req_addr[nreq] = mem_addr_o;
        nreq++;
      end
      if (hyper_dq_oe_o) begin
        if (first_beat < 0) first_beat = k;
        beats[nbeat] = hyper_dq_o;
        beat_rwds[nbeat] = hyper_rwds_o & {2{hyper_rwds_oe_o}};
        nbeat++;
      end
    end
    end_txn();
  endtask

  task automatic write_txn(input logic rs, input logic lin, input logic [31:0] a, input int lat, input int n);
    fill_req = 0;
    any_oe = 1'b0;
    send_ca(1'b0, rs, lin, a);
    for (int k = 1; k < lat; k++) begin
      drive(1'b0, 16'h0, 2'b11);
      if (mem_req_o) fill_req++;
      any_oe = any_oe | hyper_dq_oe_o;
    end
    for (int i = 0; i < n; i++) begin
      drive(1'b0, wdat[i], wrw[i]);
      wreq[i] = mem_req_o;
      wwe[i] = mem_we_o;
      waddr[i] = mem_addr_o;
      wbe[i] = mem_be_o;
      wwd[i] = mem_wdata_o;
      any_oe = any_oe | hyper_dq_oe_o | hyper_rwds_oe_o;
    end
    end_txn();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #2;
    total++; if (hyper_dq_oe_o !== 1'b0) $display("FAIL reset_dq_oe: got %b want 0", hyper_dq_oe_o); else passed++;
    total++; if (hyper_rwds_oe_o !== 1'b0) $display("FAIL reset_rwds_oe: got %b want 0", hyper_rwds_oe_o); else passed++;
    total++; if (mem_req_o !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req_o); else passed++;
    total++; if (cr0_o !== 16'h8F6F) $display("FAIL reset_cr0: got %h want 8f6f", cr0_o); else passed++;
    total++; if (hyper_dq_o !== 16'h0) $display("FAIL reset_dq: got %h want 0000", hyper_dq_o); else passed++;
    rst_i = 1'b0;
    drive(1'b1, 16'h0, 2'b00);
    drive(1'b1, 16'h0, 2'b00);
  endtask

  task automatic test_linear_write();
    logic [1:0] exp_be [4] = '{2'b11, 2'b10, 2'b11, 2'b01};
    wdat = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    wrw = '{2'b00, 2'b01, 2'b00, 2'b10};
    write_txn(1'b0, 1'b1, 32'h100, MEM_LAT, 4);
    total++; if (ca_oe !== 1'b1) $display("FAIL wr_ca_rwds_oe: got %b want 1", ca_oe); else passed++;
    total++; if (ca_rwds !== CA_RW) $display("FAIL wr_ca_rwds: got %b want %b", ca_rwds, CA_RW); else passed++;
    total++; if (fill_req !== 0) $display("FAIL wr_lat_req: got %0d want 0", fill_req); else passed++;
    total++; if (any_oe !== 1'b0) $display("FAIL wr_oe: got %b want 0", any_oe); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (wreq[i] !== 1'b1 || wwe[i] !== 1'b1) $display("FAIL wr_req%0d: got req %b we %b want 1 1", i, wreq[i], wwe[i]); else passed++;
      total++; if (waddr[i] !== ADDR_W'(32'h100 + i)) $display("FAIL wr_addr%0d: got %h want %h", i, waddr[i], 32'h100 + i); else passed++;
      total++; if (wbe[i] !== exp_be[i]) $display("FAIL wr_be%0d: got %b want %b", i, wbe[i], exp_be[i]); else passed++;
      total++; if (wwd[i] !== wdat[i]) $display("FAIL wr_data%0d: got %h want %h", i, wwd[i], wdat[i]); else passed++;
    end
    total++; if (req_after !== 1'b0) $display("FAIL wr_req_after_cs: got %b want 0", req_after); else passed++;
  endtask

  task automatic test_linear_read();
    // memory was preset to aaaa, so masked bytes keep aa
    logic [15:0] exp_d [4] = '{16'h0001, 16'h00AA, 16'h0003, 16'hAA04};
    read_txn(1'b0, 1'b1, 32'h100, 4);
    total++; if (nbeat !== 4) $display("FAIL rd_beats: got %0d want 4", nbeat); else passed++;
    total++; if (first_beat !== MEM_LAT) $display("FAIL rd_latency: got %0d want %0d", first_beat, MEM_LAT); else passed++;
    total++; if (ca_rwds !== CA_RW) $display("FAIL rd_ca_rwds: got %b want %b", ca_rwds, CA_RW); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (beats[i] !== exp_d[i]) $display("FAIL rd_data%0d: got %h want %h", i, beats[i], exp_d[i]); else passed++;
      total++; if (beat_rwds[i] !== 2'b10) $display("FAIL rd_rwds%0d: got %b want 10", i, beat_rwds[i]); else passed++;
      total++; if (req_addr[i] !== ADDR_W'(32'h100 + i)) $display("FAIL rd_addr%0d: got %h want %h", i, req_addr[i], 32'h100 + i); else passed++;
    end
    total++; if (req_after !== 1'b0) $display("FAIL rd_req_after_cs: got %b want 0", req_after); else passed++;
    total++; if (oe_after !== 1'b0) $display("FAIL rd_oe_after_cs: got %b want 0", oe_after); else passed++;
  endtask

  task automatic test_wrapped_read();
    logic [ADDR_W-1:0] exp_a [4] = '{20'h10E, 20'h10F, 20'h100, 20'h101};
    read_txn(1'b0, 1'b0, 32'h10E, 4);
    for (int i = 0; i < 4; i++) begin
      total++; if (req_addr[i] !== exp_a[i]) $display("FAIL wrap_addr%0d: got %h want %h", i, req_addr[i], exp_a[i]); else passed++;
    end
    total++; if (beats[2] !== 16'h0001) $display("FAIL wrap_data2: got %h want 0001", beats[2]); else passed++;
  endtask

  task automatic test_reg_read();
    read_txn(1'b1, 1'b0, 32'h0, 2);
    total++; if (first_beat !== 6) $display("FAIL id0_latency: got %0d want 6", first_beat); else passed++;
    total++; if (beats[0] !== 16'h0C81 || beats[1] !== 16'h0C81) $display("FAIL id0_data: got %h %h want 0c81", beats[0], beats[1]); else passed++;
    total++; if (nreq !== 0) $display("FAIL id0_mem_req: got %0d want 0", nreq); else passed++;
    read_txn(1'b1, 1'b0, 32'h800, 1);
    total++; if (beats[0] !== 16'h8F6F) $display("FAIL cr0_read: got %h want 8f6f", beats[0]); else passed++;
  endtask

  task automatic test_reg_write();
    wdat[0] = 16'h1234;
    write_txn(1'b1, 1'b0, 32'h0, 1, 1);
    total++; if (cr0_o !== 16'h8F6F) $display("FAIL regwr_id0_drop: got %h want 8f6f", cr0_o); else passed++;
    wdat[0] = 16'h8F3F;
    write_txn(1'b1, 1'b0, 32'h800, 1, 1);
    total++; if (cr0_o !== 16'h8F3F) $display("FAIL regwr_cr0: got %h want 8f3f", cr0_o); else passed++;
    total++; if (wreq[0] !== 1'b0) $display("FAIL regwr_mem_req: got %b want 0", wreq[0]); else passed++;
    read_txn(1'b0, 1'b1, 32'h100, 1);
    total++; if (first_beat !== LAT3) $display("FAIL lat3_latency: got %0d want %0d", first_beat, LAT3); else passed++;
    total++; if (ca_rwds !== CA_RW) $display("FAIL lat3_ca_rwds: got %b want %b", ca_rwds, CA_RW); else passed++;
    total++; if (beats[0] !== 16'h0001) $display("FAIL lat3_data: got %h want 0001", beats[0]); else passed++;
    wdat[0] = 16'h8F1F;
    write_txn(1'b1, 1'b0, 32'h800, 1, 1);
    read_txn(1'b0, 1'b1, 32'h102, 1);
    total++; if (first_beat !== LAT3) $display("FAIL minlat_latency: got %0d want %0d", first_beat, LAT3); else passed++;
    total++; if (beats[0] !== 16'h0003) $display("FAIL minlat_data: got %h want 0003", beats[0]); else passed++;
    @(negedge clk_i);
    hyper_reset_ni = 1'b0;
    @(negedge clk_i);
    hyper_reset_ni = 1'b1;
    #2;
    total++; if (cr0_o !== 16'h8F6F) $display("FAIL hyper_reset_cr0: got %h want 8f6f", cr0_o); else passed++;
  endtask

  task automatic test_cs_abort();
    send_ca(1'b1, 1'b0, 1'b1, 32'h100);
    fill_req = 0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 16'h0, 2'b00);
      if (mem_req_o) fill_req++;
    end
    end_txn();
    total++; if (fill_req + int'(req_after) !== 0) $display("FAIL abort_lat_req: got %0d want 0", fill_req + int'(req_after)); else passed++;
    total++; if (oe_after !== 1'b0) $display("FAIL abort_lat_oe: got %b want 0", oe_after); else passed++;
    read_txn(1'b0, 1'b1, 32'h100, 2);
    total++; if (beats[1] !== 16'h00AA) $display("FAIL abort_rd_data: got %h want 00aa", beats[1]); else passed++;
    total++; if (req_after !== 1'b0) $display("FAIL abort_rd_req: got %b want 0", req_after); else passed++;
    total++; if (oe_after !== 1'b0) $display("FAIL abort_rd_oe: got %b want 0", oe_after); else passed++;
    read_txn(1'b0, 1'b1, 32'h103, 1);
    total++; if (first_beat !== MEM_LAT) $display("FAIL abort_next_latency: got %0d want %0d", first_beat, MEM_LAT); else passed++;
    total++; if (beats[0] !== 16'hAA04) $display("FAIL abort_next_data: got %h want aa04", beats[0]); else passed++;
  endtask

  initial begin
    test_reset();
    test_linear_write();
    test_linear_read();
    test_wrapped_read();
    test_reg_read();
    test_reg_write();
    test_cs_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
